// File: rtl/sl_word_transmitter.sv
// sl_word_transmitter
// Sends one 8/16/32-bit word plus an odd parity bit over a two-wire
// pulse line: a low pulse on sl0 encodes a 0, a low pulse on sl1 a 1.
// Each bit is a low half-period followed by a high half-period. After the
// parity bit both lines stay high for a fixed gap, then done pulses once
// and the block becomes ready again.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready high, both lines high, waiting for an enable edge
// PULSE | low half of the current bit on the selected line
// SPACE | high half of the current bit, both lines high
// GAP   | inter-word idle time after the parity bit, both lines high

module sl_word_transmitter #(
   parameter int HALF_BIT_CLKS = 4,
   parameter int GAP_BITS      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] data,
   input  logic [1:0]  mode,
   output logic        ready,
   output logic        done,
   output logic        sl0,
   output logic        sl1
);

   // Timer reload values; the timer counts down and a phase ends when it
   // reads zero, so a load of L gives a phase of L+1 cycles.
   localparam logic [12:0] HALF_LOAD = 13'(HALF_BIT_CLKS - 1);
   localparam logic [12:0] GAP_LOAD  = 13'(GAP_BITS * 2 * HALF_BIT_CLKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      SPACE = 2'd2,
      GAP   = 2'd3
   } stateT;

   stateT       state, stateNext;
   logic        enableD;
   logic [12:0] timer, timerNext;
   logic [5:0]  bitsLeft, bitsLeftNext;
   logic [32:0] frame, frameNext;
   logic        readyNext, doneNext, sl0Next, sl1Next;
   logic        start;
   logic [32:0] startFrame;
   logic [5:0]  startBits;

   // Rising edge of enable, only honoured while idle.
   assign start = enable & ~enableD & ready;

   // Build the outgoing frame MSB-aligned: data bits first, then parity,
   // so the bit on the wire is always frame[32]. startBits counts the bits
   // still to follow the first one (N data + parity - 1 = N).
   always_comb begin
      startFrame = '0;
      startBits  = 6'd32;
      case (mode)
         2'b00: begin
            startFrame = {data[7:0], ~^data[7:0], 24'd0};
            startBits  = 6'd8;
         end
         2'b01: begin
            startFrame = {data[15:0], ~^data[15:0], 16'd0};
            startBits  = 6'd16;
         end
         default: begin
            startFrame = {data, ~^data};
            startBits  = 6'd32;
         end
      endcase
   end

   // Next-state and next-output logic; both lines default high so they can
   // never be low together and drop only while a bit is in PULSE.
   always_comb begin
      stateNext    = state;
      timerNext    = timer;
      bitsLeftNext = bitsLeft;
      frameNext    = frame;
      readyNext    = ready;
      doneNext     = 1'b0;
      sl0Next      = 1'b1;
      sl1Next      = 1'b1;
      case (state)
         IDLE: begin
            if (start) begin
               stateNext    = PULSE;
               timerNext    = HALF_LOAD;
               bitsLeftNext = startBits;
               frameNext    = startFrame;
               readyNext    = 1'b0;
               sl0Next      = startFrame[32];
               sl1Next      = ~startFrame[32];
            end
         end
         PULSE: begin
            sl0Next = frame[32];
            sl1Next = ~frame[32];
            if (timer == 13'd0) begin
               stateNext = SPACE;
               timerNext = HALF_LOAD;
               sl0Next   = 1'b1;
               sl1Next   = 1'b1;
            end else begin
               timerNext = timer - 13'd1;
            end
         end
         SPACE: begin
            if (timer == 13'd0) begin
               if (bitsLeft == 6'd0) begin
                  stateNext = GAP;
                  timerNext = GAP_LOAD;
               end else begin
                  stateNext    = PULSE;
                  timerNext    = HALF_LOAD;
                  bitsLeftNext = bitsLeft - 6'd1;
                  frameNext    = {frame[31:0], 1'b0};
                  sl0Next      = frame[31];
                  sl1Next      = ~frame[31];
               end
            end else begin
               timerNext = timer - 13'd1;
            end
         end
         GAP: begin
            if (timer == 13'd0) begin
               stateNext = IDLE;
               readyNext = 1'b1;
               doneNext  = 1'b1;
               frameNext = '0;
            end else begin
               timerNext = timer - 13'd1;
            end
         end
      endcase
   end

   // State, counters and registered outputs; reset aborts any word at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         enableD  <= 1'b0;
         timer    <= '0;
         bitsLeft <= '0;
         frame    <= '0;
         ready    <= 1'b1;
         done     <= 1'b0;
         sl0      <= 1'b1;
         sl1      <= 1'b1;
      end else begin
         state    <= stateNext;
         enableD  <= enable;
         timer    <= timerNext;
         bitsLeft <= bitsLeftNext;
         frame    <= frameNext;
         ready    <= readyNext;
         done     <= doneNext;
         sl0      <= sl0Next;
         sl1      <= sl1Next;
      end
   end

endmodule

// File: tb/tb_sl_word_transmitter.sv
// Bench for sl_word_transmitter with HALF_BIT_CLKS=2, GAP_BITS=4.
module tb_sl_word_transmitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] data;
   logic [1:0]  mode;
   logic        ready, done, sl0, sl1;

   int          compared  = 0;
   int          failed    = 0;
   int          doneCount = 0;
   int          capCount  = 0;
   logic [63:0] capBits   = '0;
   int          run0 = 0;
   int          run1 = 0;

   typedef struct {
      logic [1:0]  m;
      logic [31:0] d;
      int          nb;
      logic        par;
      int          len;
   } vecT;

   vecT vecs[8];

   sl_word_transmitter #(.HALF_BIT_CLKS(2), .GAP_BITS(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .data(data), .mode(mode),
      .ready(ready), .done(done), .sl0(sl0), .sl1(sl1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Line monitor: overlap check, pulse length check, captured bit stream.
   initial begin
      forever begin
         @(negedge clk);
         if (!sl0 && !sl1) begin
            compared++;
            failed++;
            $display("FAIL overlap: sl0=0 sl1=0 at %0t, required never both low", $time);
         end
         if (done) doneCount++;
         if (!sl0) run0++;
         else if (run0 != 0) begin
            check("pulse_len_sl0", 64'(run0), 64'd2);
            capBits = {capBits[62:0], 1'b0};
            capCount++;
            run0 = 0;
         end
         if (!sl1) run1++;
         else if (run1 != 0) begin
            check("pulse_len_sl1", 64'(run1), 64'd2);
            capBits = {capBits[62:0], 1'b1};
            capCount++;
            run1 = 0;
         end
      end
   end

   task automatic expectFrame(input string name, input logic [31:0] d, input int nb, input logic par);
      logic [63:0] expv;
      expv = '0;
      for (int i = nb - 1; i >= 0; i--) expv = {expv[62:0], d[i]};
      expv = {expv[62:0], par};
      check({name, "_bitcount"}, 64'(capCount), 64'(nb + 1));
      check({name, "_bits"}, capBits, expv);
   endtask

   // Starts a word, measures start-to-ready latency, checks done and frame.
   task automatic runWord(input string name, input logic [1:0] m, input logic [31:0] d,
                          input int nb, input logic par, input int expLen);
      int cnt;
      int doneBefore;
      capCount   = 0;
      capBits    = '0;
      doneBefore = doneCount;
      @(negedge clk);
      mode = m; data = d; enable = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!ready && cnt < 1000);
      check({name, "_latency"}, 64'(cnt - 1), 64'(expLen));
      check({name, "_done_hi"}, 64'(done), 64'd1);
      @(negedge clk);
      check({name, "_done_lo"}, 64'(done), 64'd0);
      enable = 1'b0;
      data = 32'h5A5A_5A5A;
      repeat (2) @(negedge clk);
      expectFrame(name, d, nb, par);
      check({name, "_done_count"}, 64'(doneCount - doneBefore), 64'd1);
   endtask

   initial begin
      int cnt;
      int doneBefore;

      vecs[0] = '{2'b00, 32'h0000_00A5, 8,  1'b1, 52};
      vecs[1] = '{2'b01, 32'h1234_8000, 16, 1'b0, 84};
      vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32, 1'b1, 148};
      vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32, 1'b1, 148};
      vecs[4] = '{2'b00, 32'h0000_0000, 8,  1'b1, 52};
      vecs[5] = '{2'b00, 32'hFFFF_FF01, 8,  1'b0, 52};
      vecs[6] = '{2'b01, 32'hABCD_FFFE, 16, 1'b0, 84};
      vecs[7] = '{2'b10, 32'h8000_0001, 32, 1'b1, 148};

      reset = 1'b1; enable = 1'b0; data = '0; mode = 2'b00;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_done", 64'(done), 64'd0);
      check("reset_sl0", 64'(sl0), 64'd1);
      check("reset_sl1", 64'(sl1), 64'd1);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         runWord($sformatf("vec%0d", v), vecs[v].m, vecs[v].d, vecs[v].nb, vecs[v].par, vecs[v].len);
      end

      // Second edge mid-word with data change: ignored, first word intact.
      capCount = 0; capBits = '0; doneBefore = doneCount;
      @(negedge clk);
      mode = 2'b00; data = 32'h0000_00A5; enable = 1'b1;
      cnt = 0;
      repeat (3) begin @(negedge clk); cnt++; end
      enable = 1'b0;
      repeat (7) begin @(negedge clk); cnt++; end
      enable = 1'b1; data = 32'h0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!ready && cnt < 1000);
      check("ignore_latency", 64'(cnt - 1), 64'd52);
      repeat (20) @(negedge clk);
      check("ignore_ready_held", 64'(ready), 64'd1);
      check("ignore_bitcount", 64'(capCount), 64'd9);
      check("ignore_bits", capBits, 64'h14B);
      check("ignore_done_count", 64'(doneCount - doneBefore), 64'd1);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      runWord("after_ignore", 2'b00, 32'h0, 8, 1'b1, 52);

      // Reset mid-word: immediate abort, no done, then a clean word.
      capCount = 0; capBits = '0; doneBefore = doneCount;
      @(negedge clk);
      mode = 2'b00; data = 32'h0000_00A5; enable = 1'b1;
      repeat (15) @(negedge clk);
      reset = 1'b1; enable = 1'b0;
      @(negedge clk);
      check("abort_sl0", 64'(sl0), 64'd1);
      check("abort_sl1", 64'(sl1), 64'd1);
      check("abort_ready", 64'(ready), 64'd1);
      check("abort_done", 64'(done), 64'd0);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      check("abort_no_done", 64'(doneCount - doneBefore), 64'd0);
      check("abort_partial_count", 64'(capCount), 64'd4);
      check("abort_partial_bits", capBits, 64'hA);
      check("abort_idle_ready", 64'(ready), 64'd1);
      runWord("after_abort", 2'b00, 32'h0000_00A5, 8, 1'b1, 52);

      // Enable already high at reset release starts on the first edge.
      @(negedge clk);
      reset = 1'b1; enable = 1'b1; mode = 2'b00; data = 32'h0000_0003;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      capCount = 0; capBits = '0;
      @(negedge clk);
      check("start_at_release", 64'(ready), 64'd0);
      cnt = 1;
      while (!ready && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      check("release_latency", 64'(cnt - 1), 64'd52);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      expectFrame("release", 32'h3, 8, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sl_word_transmitter.md
SL_WORD_TRANSMITTER -- requirements
Module: sl_word_transmitter

Interface
REQ-001 Parameter HALF_BIT_CLKS, default 4: clk cycles per half bit period; legal range 1..255.
REQ-002 Parameter GAP_BITS, default 4: idle bit periods after each word; legal range 1..15.
REQ-003 Port clk  input  1  single clock for the whole block.
REQ-004 Port reset  input  1  synchronous, active-high reset sampled on rising edge of clk.
REQ-005 Port enable  input  1  start request, already synchronised to clk; only its rising edge matters.
REQ-006 Port data  input  32  word to send; low N bits transmitted.
REQ-007 Port mode  input  2  word length: 00 = 8 bits, 01 = 16 bits, 10 = 32 bits, 11 = 32 bits.
REQ-008 Port ready  output  1  high when idle and able to accept a start.
REQ-009 Port done  output  1  one-cycle pulse at end of the inter-word gap.
REQ-010 Port sl0  output  1  serial line for 0 bits; idle high; low pulse encodes a 0 bit.
REQ-011 Port sl1  output  1  serial line for 1 bits; idle high; low pulse encodes a 1 bit.

Function
REQ-012 All outputs SHALL be registered; sl0 and sl1 SHALL never be low in the same cycle.
REQ-013 The block SHALL register enable into enable_d each cycle; start = enable AND NOT enable_d AND ready.
REQ-014 States SHALL be IDLE, PULSE, SPACE and GAP; ready SHALL be high only in IDLE.
REQ-015 On start at edge k the block SHALL latch data and mode, set ready low, enter PULSE and drive the first bit's line low from edge k onward.
REQ-016 N = 8, 16 or 32 per latched mode; bits SHALL be sent MSB first, data[N-1] down to data[0], followed by one parity bit, for N+1 bits total.
REQ-017 The parity bit SHALL be odd: the count of ones across the N data bits plus parity is odd.
REQ-018 Each bit SHALL occupy PULSE for HALF_BIT_CLKS cycles (selected line low, other high), then SPACE for HALF_BIT_CLKS cycles (both high).
REQ-019 After the parity bit's SPACE, the block SHALL enter GAP for GAP_BITS*2*HALF_BIT_CLKS cycles with both lines high.
REQ-020 At GAP exit at edge k+(N+1+GAP_BITS)*2*HALF_BIT_CLKS, ready SHALL rise and done SHALL pulse high for exactly one cycle.
REQ-021 Rising edges of enable while ready is low SHALL be ignored and not queued; enable held high SHALL produce exactly one word.
REQ-022 Changes on data or mode after the start edge SHALL NOT affect the word in flight.
REQ-023 The bit counter and half-period counter SHALL NOT wrap within a word; the mode 11 bit count SHALL equal the mode 10 bit count.
REQ-024 A start in the same cycle that ready rises SHALL NOT occur, because ready is registered; the earliest next start is one cycle after ready rises.

Reset
REQ-025 Reset SHALL force, at the next clk edge: state IDLE, ready=1, done=0, sl0=1, sl1=1, enable_d=0, and all counters and latches to 0.
REQ-026 Reset asserted mid-word SHALL abort the word immediately, with no partial parity and no done pulse.
REQ-027 If enable is high when reset releases, enable_d=0 causes a start on the first post-reset edge; this is intended behaviour.

Verification (HALF_BIT_CLKS=2, GAP_BITS=4)
REQ-028 Case 1: mode=00, data=0x000000A5, enable rising -> line pulse order sl1,sl0,sl1,sl0,sl0,sl1,sl0,sl1, then parity on sl1; ready returns 52 cycles after start with a 1-cycle done.
REQ-029 Case 2: mode=01, data=0x12348000 -> one sl1 pulse, then fifteen sl0 pulses, then parity on sl0; ready returns after 84 cycles.
REQ-030 Case 3: mode=11, data=0xFFFFFFFF -> 32 sl1 pulses, then parity on sl1; frame matches mode=10, and ready returns after 148 cycles.
REQ-031 Case 4: second enable rising edge at cycle 10 of a word, with data changed to 0 at the same time -> first word unchanged; no second word until a new edge after ready rises.
REQ-032 Case 5: reset asserted at cycle 15 of a mode=00 word -> next edge gives sl0=sl1=1 and ready=1; no done pulse; a subsequent start sends a complete, correct word.
REQ-033 Case 6: all cases -> a checker asserts that sl0 and sl1 are never low simultaneously and that every pulse is exactly 2 cycles long.
